// File: rtl/rr_reg_arbiter.sv
// -----------------------------------------------------------------------------
// rr_reg_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share one registered
// holding stage. Each cycle at most one requester is granted. Its word is
// captured into the holding register, which drives a valid/ready output port.
// A drain and a fill can happen on the same edge, so the stage sustains one
// word per cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   req_valid  per-requester valid, bit i = requester i
//   req_data   packed requester data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  one-hot-or-zero grant back to the requesters
//   out_valid  holding register contains a word
//   out_data   holding register contents
//   out_src    index of the requester that supplied out_data
//   out_ready  downstream accepts the held word
// -----------------------------------------------------------------------------
module rr_reg_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 8,
   localparam int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [SRC_W-1:0]          out_src,
   input  logic                      out_ready
);

   localparam int unsigned NR = NUM_REQ;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [SRC_W-1:0]  out_src_q,   out_src_d;
   logic [SRC_W-1:0]  last_grant_q, last_grant_d;

   logic              can_accept;
   logic              found;
   logic [SRC_W-1:0]  winner;
   logic [DATA_W-1:0] win_data;
   logic              fill;
   logic              drain;

   assign can_accept = !out_valid_q || out_ready;

   // Search starts one past the last granted index and wraps upward, so
   // the previous winner is considered last.
   always_comb begin
      int unsigned      cand;
      logic [SRC_W-1:0] sel;
      found  = 1'b0;
      winner = '0;
      cand   = 0;
      sel    = '0;
      for (int unsigned k = 1; k <= NR; k++) begin
         cand = (32'(last_grant_q) + k) % NR;
         sel  = SRC_W'(cand);
         if (!found && req_valid[sel]) begin
            found  = 1'b1;
            winner = sel;
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (winner == SRC_W'(i)) begin
            win_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Grant is suppressed while reset is held so nothing is handed out on
   // an edge that will discard it.
   assign fill  = found && can_accept && reset;
   assign drain = out_valid_q && out_ready;

   always_comb begin
      req_ready = '0;
      if (fill) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      last_grant_d = last_grant_q;
      if (fill) begin
         out_valid_d  = 1'b1;
         out_data_d   = win_data;
         out_src_d    = winner;
         last_grant_d = winner;
      end else if (drain) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= '0;
         last_grant_q <= SRC_W'(NUM_REQ - 1);
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_reg_arbiter
//
// Self-checking bench for rr_reg_arbiter (NUM_REQ=4, DATA_W=8). A table of
// hand-derived vectors walks through reset, rotation, sparse/wrapping
// requests, backpressure, idle drain and mid-operation reset. A random phase
// follows. A behavioural model predicts grants and holding-register state,
// and a scoreboard queue tracks every accepted word until it is drained.
// -----------------------------------------------------------------------------
module tb_rr_reg_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_src;
   logic           out_ready = 1'b0;

   always #5 clk = ~clk;

   rr_reg_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   typedef struct {
      logic        rst_n;
      logic [3:0]  valid;
      logic        ready;
      logic [31:0] data;
      logic [3:0]  exp_rdy;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic [1:0] s;
   } item_t;

   vec_t  vecs[$];
   item_t sbq[$];

   int checks = 0;
   int passes = 0;

   // reference model state
   bit         m_known = 0;
   logic       m_valid = 1'b0;
   logic [7:0] m_data  = '0;
   logic [1:0] m_src   = '0;
   logic [1:0] m_last  = 2'd3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Winner = lowest set bit above last, otherwise lowest set bit overall.
   function automatic int pick(input logic [3:0] v, input logic [1:0] last);
      for (int i = int'(last) + 1; i < N; i++) if (v[i]) return i;
      for (int i = 0; i <= int'(last); i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic void add(input logic r, input logic [3:0] v, input logic rd,
                               input logic [31:0] d, input logic [3:0] e);
      vec_t x;
      x.rst_n = r; x.valid = v; x.ready = rd; x.data = d; x.exp_rdy = e;
      vecs.push_back(x);
   endfunction

   // One cycle: drive at the falling edge, check 1ns later, advance the
   // model across the next rising edge.
   task automatic tick(input logic rst_n, input logic [3:0] v, input logic rdy,
                       input logic [31:0] d, input logic [3:0] exp_rdy, input bit use_exp);
      int         w;
      logic [3:0] model_rdy;
      bit         drain;
      item_t      it;
      reset     = rst_n;
      req_valid = v;
      out_ready = rdy;
      req_data  = d;
      #1;
      w         = pick(v, m_last);
      model_rdy = '0;
      if (rst_n && w >= 0 && (!m_valid || rdy)) model_rdy[w] = 1'b1;
      if (use_exp) check("table_req_ready", 32'(req_ready), 32'(exp_rdy));
      check("model_req_ready", 32'(req_ready), 32'(model_rdy));
      if (m_known) begin
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("out_data",  32'(out_data),  32'(m_data));
         check("out_src",   32'(out_src),   32'(m_src));
      end
      if (!rst_n) begin
         m_known = 1;
         m_valid = 1'b0;
         m_data  = '0;
         m_src   = '0;
         m_last  = 2'd3;
         sbq.delete();
      end else begin
         drain = m_valid && rdy;
         if (drain) begin
            if (sbq.size() == 0) begin
               checks++;
               $display("FAIL sb_underflow: drain with empty scoreboard (t=%0t)", $time);
            end else begin
               it = sbq.pop_front();
               check("sb_data", 32'(out_data), 32'(it.d));
               check("sb_src",  32'(out_src),  32'(it.s));
            end
         end
         if (model_rdy != '0) begin
            m_valid = 1'b1;
            m_data  = d[w*8 +: 8];
            m_src   = 2'(w);
            m_last  = 2'(w);
            it.d = m_data;
            it.s = m_src;
            sbq.push_back(it);
         end else if (drain) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   localparam logic [31:0] DEF = 32'hA3A2A1A0;
   localparam logic [31:0] BP  = 32'hA35CA1A0;
   localparam logic [31:0] RM  = 32'hA3A277A0;

   initial begin
      // reset held two cycles with all requests active
      add(0, 4'b1111, 1, DEF, 4'b0000);
      add(0, 4'b1111, 1, DEF, 4'b0000);
      // rotation 0,1,2,3,0,1
      add(1, 4'b1111, 1, DEF, 4'b0001);
      add(1, 4'b1111, 1, DEF, 4'b0010);
      add(1, 4'b1111, 1, DEF, 4'b0100);
      add(1, 4'b1111, 1, DEF, 4'b1000);
      add(1, 4'b1111, 1, DEF, 4'b0001);
      add(1, 4'b1111, 1, DEF, 4'b0010);
      // sparse and wrapping
      add(1, 4'b1000, 1, DEF, 4'b1000);
      add(1, 4'b0101, 1, DEF, 4'b0001);
      add(1, 4'b0101, 1, DEF, 4'b0100);
      add(1, 4'b0101, 1, DEF, 4'b0001);
      add(1, 4'b1000, 1, DEF, 4'b1000);
      add(1, 4'b0010, 1, DEF, 4'b0010);
      // backpressure: fill 5C from requester 2, stall 5 cycles, release
      add(1, 4'b0100, 1, BP,  4'b0100);
      for (int i = 0; i < 5; i++) add(1, 4'b1111, 0, BP, 4'b0000);
      add(1, 4'b1111, 1, BP,  4'b1000);
      // idle drain
      add(1, 4'b0010, 1, DEF, 4'b0010);
      add(1, 4'b0000, 1, DEF, 4'b0000);
      add(1, 4'b0000, 1, DEF, 4'b0000);
      // reset mid-operation with 77 held and stalled
      add(1, 4'b0010, 1, RM,  4'b0010);
      add(1, 4'b0000, 0, RM,  4'b0000);
      add(0, 4'b1111, 0, RM,  4'b0000);
      add(1, 4'b1111, 1, DEF, 4'b0001);
      add(1, 4'b1111, 0, DEF, 4'b0000);
      add(1, 4'b1111, 1, DEF, 4'b0010);
      add(1, 4'b0000, 1, DEF, 4'b0000);
      add(1, 4'b0000, 0, DEF, 4'b0000);

      @(negedge clk);
      foreach (vecs[i]) begin
         tick(vecs[i].rst_n, vecs[i].valid, vecs[i].ready, vecs[i].data, vecs[i].exp_rdy, 1);
      end

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 49) != 0), 4'($urandom), 1'($urandom),
              $urandom, 4'b0000, 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
